// File: rtl/fusion_alu_pkg.sv
// Fusion ALU shared types.
// Opcodes, width and result bundle.
package fusion_alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SLL   = 4'd6,
    OP_SRL   = 4'd7,
    OP_SRA   = 4'd8,
    OP_SLT   = 4'd9,
    OP_SLTU  = 4'd10,
    OP_PASSB = 4'd11
  } alu_op_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            carry;
    logic            ovf;
    logic            illegal;
  } alu_res_t;

endpackage

// File: rtl/alu_ops.sv
// Fusion ALU datapath.
// Combinational result and flags.
module alu_ops
  import fusion_alu_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output alu_res_t        res
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   dif;
  logic [XLEN-1:0] inv;
  logic [4:0]      sh;
  logic [XLEN-1:0] r;
  logic            c;
  logic            v;
  logic            ill;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign sh  = b[4:0];

  not_32 u_not (
    .a (a),
    .y (inv)
  );

  // Opcode decode: result, carry, overflow.
  always_comb begin
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    ill = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        r = sum[XLEN-1:0];
        c = sum[XLEN];
        v = (a[31] == b[31]) &&
            (r[31] != a[31]);
      end
      (op == OP_SUB): begin
        r = dif[XLEN-1:0];
        c = !dif[XLEN];
        v = (a[31] != b[31]) &&
            (r[31] != a[31]);
      end
      (op == OP_AND):   r = a & b;
      (op == OP_OR):    r = a | b;
      (op == OP_XOR):   r = a ^ b;
      (op == OP_NOT):   r = inv;
      (op == OP_SLL):   r = a << sh;
      (op == OP_SRL):   r = a >> sh;
      (op == OP_SRA):
        r = $unsigned($signed(a) >>> sh);
      (op == OP_SLT):
        r = {31'd0,
             $signed(a) < $signed(b)};
      (op == OP_SLTU):
        r = {31'd0, a < b};
      (op == OP_PASSB): r = b;
      default:          ill = 1'b1;
    endcase
  end

  // Pack bundle; zero is on final result.
  always_comb begin
    res.result  = r;
    res.zero    = (r == '0);
    res.carry   = c;
    res.ovf     = v;
    res.illegal = ill;
  end

endmodule

// File: rtl/not_32.sv
// Fusion ALUOP unit: bitwise inverse.
// Purely combinational.
module not_32 (
  input  logic [31:0] a,
  output logic [31:0] y
);

  assign y = ~a;

endmodule

// File: rtl/alu_exec_stage.sv
// Fusion execute stage.
// ALU with main + skid output regs.
module alu_exec_stage
  import fusion_alu_pkg::*;
#(
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_tag,
  output logic            out_zero,
  output logic            out_carry,
  output logic            out_ovf,
  output logic            out_illegal
);

  alu_res_t        res;
  alu_res_t        main_res_q, main_res_d;
  alu_res_t        skid_res_q, skid_res_d;
  logic [TAGW-1:0] main_tag_q, main_tag_d;
  logic [TAGW-1:0] skid_tag_q, skid_tag_d;
  logic            main_v_q, main_v_d;
  logic            skid_v_q, skid_v_d;
  logic            in_ready_q, in_ready_d;
  logic            acc;
  logic            drain;

  alu_ops u_ops (
    .op  (in_op),
    .a   (in_a),
    .b   (in_b),
    .res (res)
  );

  assign acc   = in_valid && in_ready_q;
  assign drain = main_v_q && out_ready;

  // Steer accepts/drains between main and skid.
  always_comb begin
    main_v_d   = main_v_q;
    main_res_d = main_res_q;
    main_tag_d = main_tag_q;
    skid_v_d   = skid_v_q;
    skid_res_d = skid_res_q;
    skid_tag_d = skid_tag_q;
    if (drain && skid_v_q) begin
      main_v_d   = 1'b1;
      main_res_d = skid_res_q;
      main_tag_d = skid_tag_q;
      skid_v_d   = 1'b0;
    end else if (!main_v_q || drain) begin
      main_v_d = acc;
      if (acc) begin
        main_res_d = res;
        main_tag_d = in_tag;
      end
    end else if (acc) begin
      skid_v_d   = 1'b1;
      skid_res_d = res;
      skid_tag_d = in_tag;
    end
    in_ready_d = !skid_v_d;
  end

  // State registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q   <= 1'b0;
      main_res_q <= '0;
      main_tag_q <= '0;
      skid_v_q   <= 1'b0;
      skid_res_q <= '0;
      skid_tag_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_v_q   <= main_v_d;
      main_res_q <= main_res_d;
      main_tag_q <= main_tag_d;
      skid_v_q   <= skid_v_d;
      skid_res_q <= skid_res_d;
      skid_tag_q <= skid_tag_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_v_q;
  assign out_result  = main_res_q.result;
  assign out_tag     = main_tag_q;
  assign out_zero    = main_res_q.zero;
  assign out_carry   = main_res_q.carry;
  assign out_ovf     = main_res_q.ovf;
  assign out_illegal = main_res_q.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage.
// Directed vectors, fixed expectations.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_zero;
  logic        out_carry;
  logic        out_ovf;
  logic        out_illegal;

  int vecs = 0;
  int errs = 0;

  alu_exec_stage #(.TAGW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_zero    (out_zero),
    .out_carry   (out_carry),
    .out_ovf     (out_ovf),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  // flags = {zero, carry, ovf, illegal}
  task automatic run(input string nm,
                     input logic [3:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [4:0] tg,
                     input logic [31:0] er,
                     input logic [3:0] ef);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tg;
    in_valid = 1'b1;
    chk({nm, ".rdy"}, 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk({nm, ".vld"}, 32'(out_valid), 1);
    chk({nm, ".res"}, out_result, er);
    chk({nm, ".tag"}, 32'(out_tag), 32'(tg));
    chk({nm, ".flg"},
        {28'd0, out_zero, out_carry,
         out_ovf, out_illegal},
        {28'd0, ef});
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_op     = 4'd0;
    in_a      = 32'd1;
    in_b      = 32'd2;
    in_tag    = 5'd9;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst.vld", 32'(out_valid), 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("post.vld", 32'(out_valid), 0);
    chk("post.rdy", 32'(in_ready), 1);
    chk("post.res", out_result, 0);
    chk("post.tag", 32'(out_tag), 0);
    chk("post.flg",
        {28'd0, out_zero, out_carry,
         out_ovf, out_illegal}, 0);

    run("not", 4'd5, 32'h0F0F_0000, 0, 7,
        32'hF0F0_FFFF, 4'b0000);
    run("addv", 4'd0, 32'h7FFF_FFFF, 1, 1,
        32'h8000_0000, 4'b0010);
    run("addc", 4'd0, 32'hFFFF_FFFF, 1, 2,
        32'h0, 4'b1100);
    run("subb", 4'd1, 3, 5, 3,
        32'hFFFF_FFFE, 4'b0000);
    run("subc", 4'd1, 5, 3, 4,
        32'h2, 4'b0100);
    run("subv", 4'd1, 32'h8000_0000, 1, 5,
        32'h7FFF_FFFF, 4'b0110);
    run("sra", 4'd8, 32'h8000_0000, 32'h24, 6,
        32'hF800_0000, 4'b0000);
    run("srl", 4'd7, 32'h8000_0000, 32'h24, 8,
        32'h0800_0000, 4'b0000);
    run("sll", 4'd6, 32'h0000_0003, 32'hFFE1, 9,
        32'h0000_0006, 4'b0000);
    run("slt", 4'd9, 32'hFFFF_FFFF, 0, 10,
        32'h1, 4'b0000);
    run("sltu", 4'd10, 32'hFFFF_FFFF, 0, 11,
        32'h0, 4'b1000);
    run("xor", 4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0,
        12, 32'hF0F0_F0F0, 4'b0000);
    run("or", 4'd3, 32'h1200_0000, 32'h34,
        13, 32'h1200_0034, 4'b0000);
    run("pass", 4'd11, 32'h1, 32'hCAFE_BABE,
        14, 32'hCAFE_BABE, 4'b0000);
    run("ill", 4'd13, 5, 6, 4,
        32'h0, 4'b1001);
    run("and", 4'd2, 32'hF0F0, 32'h0FF0, 15,
        32'h0000_00F0, 4'b0000);

    // Backpressure: fill main and skid.
    out_ready = 1'b0;
    in_op     = 4'd11;
    in_a      = 0;
    in_valid  = 1'b1;
    in_tag    = 5'd1;
    in_b      = 32'd101;
    chk("bp.rdy1", 32'(in_ready), 1);
    tick();
    in_tag = 5'd2;
    in_b   = 32'd102;
    chk("bp.rdy2", 32'(in_ready), 1);
    tick();
    in_tag = 5'd3;
    in_b   = 32'd103;
    chk("bp.rdy3", 32'(in_ready), 0);
    chk("bp.hold", 32'(out_tag), 1);
    tick();
    chk("bp.stall", 32'(in_ready), 0);
    chk("bp.stab", 32'(out_tag), 1);
    chk("bp.stabr", out_result, 101);
    out_ready = 1'b1;
    chk("bp.v1", 32'(out_valid), 1);
    tick();
    chk("bp.t2", 32'(out_tag), 2);
    chk("bp.r2", out_result, 102);
    chk("bp.rdyup", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("bp.t3", 32'(out_tag), 3);
    chk("bp.r3", out_result, 103);
    chk("bp.v3", 32'(out_valid), 1);
    tick();
    chk("bp.empty", 32'(out_valid), 0);

    // Reset while both entries are held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr.vld", 32'(out_valid), 0);
    chk("mr.rdy", 32'(in_ready), 1);
    out_ready = 1'b1;
    tick();
    chk("mr.idle", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage of the Fusion core that wraps the combinational ALUOP units (`not_32` and its siblings). It accepts an opcode, two 32-bit operands and a destination tag from decode/issue over a valid/ready handshake. It computes the selected operation and result flags, and presents them to writeback through a two-entry skid output register. Latency is one cycle, throughput is one operation per cycle, and `in_ready` is a registered signal.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `TAGW`, 5, destination-register tag width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: operation presented by issue.
- `in_ready` output 1: stage can accept; registered.
- `in_op` input 4: opcode (see Operation).
- `in_a` input XLEN: operand A.
- `in_b` input XLEN: operand B; shift amount is `in_b[4:0]`.
- `in_tag` input TAGW: destination tag, passed through unchanged.
- `out_valid` output 1: result valid to writeback.
- `out_ready` input 1: writeback accepts.
- `out_result` output XLEN: result.
- `out_tag` output TAGW: tag of the result.
- `out_zero` output 1: `out_result == 0`.
- `out_carry` output 1: carry / no-borrow.
- `out_ovf` output 1: signed overflow.
- `out_illegal` output 1: opcode was 12–15.

## Operation
- Opcodes:
  - 0 ADD
  - 1 SUB (a−b)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT (~a, b ignored)
  - 6 SLL
  - 7 SRL
  - 8 SRA
  - 9 SLT (signed, result 0/1)
  - 10 SLTU (unsigned, result 0/1)
  - 11 PASSB
  - 12–15 illegal: result 0, `out_illegal=1`, zero=1, carry=0, ovf=0.
- Carry:
  - ADD: bit 32 of the 33-bit unsigned sum.
  - SUB: 1 when a ≥ b unsigned (no borrow).
  - All other opcodes: 0.
- Overflow:
  - ADD: a[31]==b[31] && r[31]!=a[31].
  - SUB: a[31]!=b[31] && r[31]!=a[31].
  - All other opcodes: 0.
- Shifts use `b[4:0]` only; `b[31:5]` is ignored. SRA replicates a[31].
- Zero flag is computed on the final 32-bit result for every opcode.
- Storage is a main output register plus one skid register; each holds {result, tag, flags, valid}.
- Accept:
  - An input is accepted when `in_valid && in_ready`.
  - If the main register is empty or is draining this cycle (`out_ready`), the operation goes to main.
  - Otherwise it goes to skid.
- Drain: on `out_valid && out_ready`, the main register takes the skid contents if the skid is full, else it takes the new accept if any, else it becomes empty.
- `in_ready` next-state is `!skid_full_next`, so it deasserts only once the skid register holds an entry.
- Ordering is strictly FIFO; no reordering, no dropped entries.
- Simultaneous accept and drain with skid full is impossible, because `in_ready=0` in that state.

## Timing
- Reset:
  - `out_valid=0`, skid empty, `in_ready=1`.
  - `out_result`, `out_tag` and all flags read 0.
  - Reset in mid-operation discards both entries on the next edge. Any `in_valid` in the reset cycle is not accepted.
- Latency: accepted in cycle N, visible on `out_*` in cycle N+1 when the output path is free.
- Stall: with `out_ready=0`, the stage absorbs at most two operations. `in_ready` falls in the cycle after the second accept.
- Outputs stay stable while `out_valid && !out_ready`.
- After a stall releases, the skid entry drains one cycle after the main entry. `in_ready` rises the cycle after the skid empties.

## Structure
- Shared package `fusion_alu_pkg` holds:
  - the opcode enum `alu_op_t` with the 12 named values;
  - `XLEN`;
  - a packed struct `alu_res_t` = {result, zero, carry, ovf, illegal}.
- Sub-module `alu_ops`: purely combinational, instantiates `not_32` for opcode 5, and produces `alu_res_t` from op/a/b.
- `alu_exec_stage` contains only the handshake, the main register and the skid register.

## Test plan
- Reset with `in_valid=1` held → `out_valid=0` and `in_ready=1` in the cycle after reset; no accept occurs during reset.
- NOT: a=0x0F0F_0000, tag=7 → one cycle later: result 0xF0F0_FFFF, tag 7, zero=0, carry=0, ovf=0.
- ADD a=0x7FFF_FFFF, b=1 → result 0x8000_0000, ovf=1, carry=0.
- ADD a=0xFFFF_FFFF, b=1 → result 0, zero=1, carry=1, ovf=0.
- SUB a=3, b=5 → result 0xFFFF_FFFE, carry=0.
- SRA a=0x8000_0000, b=0x24 (shift 4) → result 0xF800_0000.
- SLT a=0xFFFF_FFFF, b=0 → 1; SLTU with the same operands → 0.
- Backpressure:
  - `out_ready=0`, three back-to-back ops tagged 1, 2, 3.
  - Required: tags 1 and 2 accepted, `in_ready=0` before tag 3 is accepted.
  - Release `out_ready` → tags 1, 2, 3 emerge in order on consecutive cycles with no loss or duplication.
- Illegal opcode 13, tag 4 → result 0, illegal=1, zero=1. The following legal op completes normally.
